gate_lane_pipe: RTL and testbench
=================================

Name: gate_lane_pipe

Overview:
- Parametrised successor to the single-bit AND cell: applies a selectable bitwise gate (AND/OR/XOR) to LANES lanes of WIDTH-bit operands.
- Results pass through a DEPTH-stage elastic valid/ready pipeline.
- Also produces per-lane reduction flags and a beat counter.
- Sits in sv regression designs as a reusable, overridable-parameter datapath leaf.
- Derived constants are generate-scope localparams and are not overridable.

Parameters:
- WIDTH, 8, bits per lane (>=1).
- LANES, 4, number of independent lanes (>=1).
- DEPTH, 2, pipeline register stages (>=1).
- MODE, 0, gate select: 0=AND, 1=OR, 2=XOR. Any other value is an elaboration error.
- CNT_W, 16, width of the accepted-beat counter.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  operand beat valid
- in_ready  output  1  pipeline can accept a beat
- a  input  LANES*WIDTH  operand A; lane k = a[k*WIDTH +: WIDTH]
- b  input  LANES*WIDTH  operand B, same packing as a
- out_valid  output  1  result beat valid
- out_ready  input  1  downstream accepts the result
- o  output  LANES*WIDTH  gated result, lane-packed like a
- red  output  LANES  per-lane flag: red[k] = |o lane k (lane result nonzero)
- beat_cnt  output  CNT_W  count of result beats accepted downstream

Behaviour:
- Reset (rst_n low, asynchronous): all stage valid bits 0, stage data 0, beat_cnt 0. Outputs: out_valid=0, o=0, red=0, beat_cnt=0. in_ready=1 while held in reset and after release.
- Gate: stage-0 data = a OP b, computed bitwise per lane. No carries; width is preserved.
- red is computed from the final-stage data. It is registered with that data, not recomputed from inputs.
- Stage i holds (v_i, d_i). Stage i is numbered 0..DEPTH-1; stage DEPTH-1 drives out_valid/o.
- rdy_i = !v_i || rdy_{i+1}, with rdy_DEPTH = out_ready. in_ready = rdy_0, purely combinational.
- Stage i loads on rdy_i: v_i <= v_{i-1} (v_-1 = in_valid), d_i <= d_{i-1}.
  - d_i loads only when the incoming valid is 1; otherwise d_i holds its value.
  - Bubbles therefore do not corrupt visible data.
- Transfers:
  - Input transfer = in_valid && in_ready.
  - Output transfer = out_valid && out_ready.
  - Both may occur in the same cycle; the pipeline shifts by one with no loss.
- Latency: exactly DEPTH cycles from input transfer to out_valid when downstream never stalls. Throughput is 1 beat/cycle.
- Full: with all DEPTH stages valid and out_ready=0, in_ready=0. Held data and out_valid stay stable until accepted.
- Empty: out_valid=0, and o/red hold their last values.
- Valid/ready rules:
  - out_valid, once high, stays high with o stable until out_ready.
  - The bench must hold a/b stable while in_valid && !in_ready. The block does not check this.
- beat_cnt increments by 1 on each output transfer and wraps modulo 2^CNT_W (all-ones -> 0) with no flag.
- Reset mid-operation: in-flight beats are discarded and beat_cnt is cleared. The first beat after reset release lands on out_valid DEPTH cycles after its acceptance.
- Parameter scope: any parameter declared inside a generate block (e.g. per-stage constants) is local and cannot be overridden by instantiation. An override attempt on such a name must fail elaboration.

Decomposition:
- Package gate_lane_pkg holds:
  - MODE encodings as constants: GATE_AND=0, GATE_OR=1, GATE_XOR=2.
  - Function gate_apply(mode, a, b).
  - Typedef for lane-packed data sized by WIDTH*LANES, provided through a parameterised struct or a macro-free localparam.
- One sub-module, gate_lane_stage: a single elastic register slice (v, d, rdy). It is instantiated DEPTH times in a generate loop.
- The top level handles the gate, red, and beat_cnt.

Test Plan:
- Reset/idle: rst_n=0 -> out_valid=0, o=0, red=4'b0000, beat_cnt=0, in_ready=1. Release with no input -> outputs unchanged.
- Streaming AND: MODE=0, WIDTH=8, LANES=4, DEPTH=2, out_ready=1; send a=32'hFF0F_00AA, b=32'h0FFF_FF55 -> two cycles later o=32'h0F0F_0000, red=4'b1100. Then 100 back-to-back beats -> beat_cnt=101, no bubbles.
- Backpressure: out_ready=0 and 3 beats offered -> 2 accepted, in_ready=0 on the 3rd, first result held stable. Raise out_ready -> results emerge in order, one per cycle, no duplication or loss.
- Modes: MODE=1 with a=32'h0000_0001, b=32'h8000_0000 -> o=32'h8000_0001. MODE=2 with a=b=32'hDEAD_BEEF -> o=0, red=0. MODE=3 -> elaboration error.
- Counter wrap: CNT_W=4; 17 accepted beats -> beat_cnt reads 15 after the 15th, 0 after the 16th, 1 after the 17th.
- Mid-flight reset: 2 beats in flight, assert rst_n low for 1 cycle asynchronously -> out_valid drops immediately and beat_cnt=0. A new beat appears exactly DEPTH cycles after acceptance.

Source files
------------

// File: rtl/gate_lane_pkg.sv
// Shared definitions for the gate_lane_pipe datapath.
//   GATE_*         : gate-select encodings used by the MODE parameter
//   DEF_WIDTH/LANES: default lane geometry
//   lane_data_t    : lane-packed operand/result word for the default geometry
//   gate_apply()   : single-bit gate evaluation, replicated across every bit of every lane
package gate_lane_pkg;

  localparam int GATE_AND = 0;
  localparam int GATE_OR  = 1;
  localparam int GATE_XOR = 2;

  localparam int DEF_WIDTH = 8;
  localparam int DEF_LANES = 4;

  typedef logic [DEF_WIDTH*DEF_LANES-1:0] lane_data_t;

  // Bitwise gate: no carries between bits, so applying it per bit is exact
  // for any lane width.
  function automatic logic gate_apply(input int mode, input logic a, input logic b);
    logic r;
    case (mode)
      GATE_OR:  r = a | b;
      GATE_XOR: r = a ^ b;
      default:  r = a & b;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/gate_lane_stage.sv
// One elastic valid/ready register slice.
//   clk, rst_n : clock, asynchronous active-low reset
//   up_valid   : valid from the previous slice (or the pipeline input)
//   up_data    : data from the previous slice (or the gate output)
//   dn_ready   : ready from the next slice (or downstream)
//   valid/data : registered slice contents
//   ready      : slice can load this cycle (empty, or being drained)
module gate_lane_stage
  import gate_lane_pkg::*;
#(
  parameter int DATA_W = DEF_WIDTH * DEF_LANES
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              up_valid,
  input  logic [DATA_W-1:0] up_data,
  input  logic              dn_ready,
  output logic              valid,
  output logic [DATA_W-1:0] data,
  output logic              ready
);

  assign ready = !valid || dn_ready;

  // Data only loads alongside a valid beat, so bubbles leave the last
  // visible result untouched.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= 1'b0;
      data  <= '0;
    end else if (ready) begin
      valid <= up_valid;
      if (up_valid) begin
        data <= up_data;
      end
    end
  end

endmodule

// File: rtl/gate_lane_pipe.sv
// Lane-parallel bitwise gate (AND/OR/XOR) followed by a DEPTH-stage elastic
// pipeline, with per-lane nonzero flags and an accepted-beat counter.
//   clk, rst_n          : clock, asynchronous active-low reset
//   in_valid / in_ready : operand handshake
//   a, b                : lane-packed operands, lane k = [k*WIDTH +: WIDTH]
//   out_valid/out_ready : result handshake
//   o                   : lane-packed gated result from the last stage
//   red                 : red[k] = lane k of o is nonzero
//   beat_cnt            : result beats accepted downstream, wraps silently
module gate_lane_pipe
  import gate_lane_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int LANES = 4,
  parameter int DEPTH = 2,
  parameter int MODE  = 0,
  parameter int CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [LANES*WIDTH-1:0] a,
  input  logic [LANES*WIDTH-1:0] b,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [LANES*WIDTH-1:0] o,
  output logic [LANES-1:0]       red,
  output logic [CNT_W-1:0]       beat_cnt
);

  localparam int DATA_W = WIDTH * LANES;

  if (!(MODE == GATE_AND || MODE == GATE_OR || MODE == GATE_XOR)) begin : g_bad_mode
    $error("gate_lane_pipe: MODE=%0d is not a supported gate", MODE);
  end

  if (WIDTH < 1 || LANES < 1 || DEPTH < 1 || CNT_W < 1) begin : g_bad_geometry
    $error("gate_lane_pipe: WIDTH, LANES, DEPTH and CNT_W must all be >= 1");
  end

  logic [DATA_W-1:0] gate_d;

  always_comb begin
    gate_d = '0;
    for (int i = 0; i < DATA_W; i++) begin
      gate_d[i] = gate_apply(MODE, a[i], b[i]);
    end
  end

  logic              stg_v   [DEPTH];
  logic [DATA_W-1:0] stg_d   [DEPTH];
  logic              stg_rdy [DEPTH+1];

  assign stg_rdy[DEPTH] = out_ready;

  for (genvar i = 0; i < DEPTH; i++) begin : g_stage
    localparam bit FIRST = (i == 0);

    logic              up_v;
    logic [DATA_W-1:0] up_d;

    if (FIRST) begin : g_src_in
      assign up_v = in_valid;
      assign up_d = gate_d;
    end else begin : g_src_prev
      assign up_v = stg_v[i-1];
      assign up_d = stg_d[i-1];
    end

    gate_lane_stage #(
      .DATA_W (DATA_W)
    ) u_stage (
      .clk      (clk),
      .rst_n    (rst_n),
      .up_valid (up_v),
      .up_data  (up_d),
      .dn_ready (stg_rdy[i+1]),
      .valid    (stg_v[i]),
      .data     (stg_d[i]),
      .ready    (stg_rdy[i])
    );
  end

  assign in_ready  = stg_rdy[0];
  assign out_valid = stg_v[DEPTH-1];
  assign o         = stg_d[DEPTH-1];

  // Derived only from the last-stage register, so red changes exactly when o
  // does and holds through empty cycles.
  always_comb begin
    red = '0;
    for (int k = 0; k < LANES; k++) begin
      red[k] = |o[k*WIDTH +: WIDTH];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      beat_cnt <= '0;
    end else if (out_valid && out_ready) begin
      beat_cnt <= beat_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_gate_lane_pipe.sv
module tb_gate_lane_pipe;
  import gate_lane_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic       out_ready = 1'b1;
  lane_data_t a = '0;
  lane_data_t b = '0;

  logic       in_ready, out_valid;
  lane_data_t o;
  logic [3:0] red;
  logic [15:0] beat_cnt;

  logic       or_in_ready, or_out_valid;
  lane_data_t or_o;
  logic [3:0] or_red;
  logic [15:0] or_cnt;

  logic       xor_in_ready, xor_out_valid;
  lane_data_t xor_o;
  logic [3:0] xor_red;
  logic [3:0] xor_cnt;

  gate_lane_pipe #(.WIDTH(8), .LANES(4), .DEPTH(2), .MODE(0), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
    .o(o), .red(red), .beat_cnt(beat_cnt)
  );

  gate_lane_pipe #(.WIDTH(8), .LANES(4), .DEPTH(2), .MODE(1), .CNT_W(16)) dut_or (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(or_in_ready),
    .a(a), .b(b), .out_valid(or_out_valid), .out_ready(out_ready),
    .o(or_o), .red(or_red), .beat_cnt(or_cnt)
  );

  gate_lane_pipe #(.WIDTH(8), .LANES(4), .DEPTH(2), .MODE(2), .CNT_W(4)) dut_xor (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(xor_in_ready),
    .a(a), .b(b), .out_valid(xor_out_valid), .out_ready(out_ready),
    .o(xor_o), .red(xor_red), .beat_cnt(xor_cnt)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // reset / idle
    #12;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_o", o, 32'd0);
    check("rst_red", 32'(red), 32'd0);
    check("rst_beat_cnt", 32'(beat_cnt), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_or_in_ready", 32'(or_in_ready), 32'd1);
    check("rst_xor_in_ready", 32'(xor_in_ready), 32'd1);
    step();
    rst_n = 1'b1;
    step();
    step();
    check("idle_out_valid", 32'(out_valid), 32'd0);
    check("idle_o", o, 32'd0);
    check("idle_beat_cnt", 32'(beat_cnt), 32'd0);
    check("idle_in_ready", 32'(in_ready), 32'd1);

    // single AND beat, latency DEPTH
    a = 32'hFF0F_00AA;
    b = 32'h0FFF_FF55;
    in_valid = 1'b1;
    check("and_in_ready", 32'(in_ready), 32'd1);
    step();
    in_valid = 1'b0;
    check("and_lat1_valid", 32'(out_valid), 32'd0);
    step();
    check("and_lat2_valid", 32'(out_valid), 32'd1);
    check("and_o", o, 32'h0F0F_0000);
    check("and_red", 32'(red), 32'b1100);
    check("or_o_first", or_o, 32'hFFFF_FFFF);
    check("or_red_first", 32'(or_red), 32'b1111);
    check("xor_o_first", xor_o, 32'hF0F0_FFFF);
    step();
    check("and_cnt1", 32'(beat_cnt), 32'd1);

    // 100 back-to-back beats
    b = 32'hFFFF_FFFF;
    for (int i = 0; i < 100; i++) begin
      a = {4{8'(i)}};
      in_valid = 1'b1;
      check("stream_in_ready", 32'(in_ready), 32'd1);
      step();
      if (i >= 1) begin
        check("stream_out_valid", 32'(out_valid), 32'd1);
        check("stream_o", o, {4{8'(i - 1)}});
      end
    end
    in_valid = 1'b0;
    step();
    check("stream_last_o", o, 32'h6363_6363);
    check("stream_last_valid", 32'(out_valid), 32'd1);
    step();
    step();
    check("empty_out_valid", 32'(out_valid), 32'd0);
    check("empty_o_hold", o, 32'h6363_6363);
    check("empty_red_hold", 32'(red), 32'b1111);
    check("stream_cnt", 32'(beat_cnt), 32'd101);

    // backpressure
    out_ready = 1'b0;
    a = 32'h1122_3344;
    in_valid = 1'b1;
    check("bp_acc0_ready", 32'(in_ready), 32'd1);
    step();
    a = 32'h5566_7788;
    check("bp_acc1_ready", 32'(in_ready), 32'd1);
    step();
    a = 32'h99AA_BBCC;
    check("bp_full_ready", 32'(in_ready), 32'd0);
    check("bp_full_valid", 32'(out_valid), 32'd1);
    check("bp_full_o", o, 32'h1122_3344);
    repeat (3) step();
    check("bp_hold_ready", 32'(in_ready), 32'd0);
    check("bp_hold_valid", 32'(out_valid), 32'd1);
    check("bp_hold_o", o, 32'h1122_3344);
    check("bp_hold_cnt", 32'(beat_cnt), 32'd101);
    out_ready = 1'b1;
    #1;
    check("bp_release_ready", 32'(in_ready), 32'd1);
    step();
    in_valid = 1'b0;
    check("bp_out2_valid", 32'(out_valid), 32'd1);
    check("bp_out2_o", o, 32'h5566_7788);
    step();
    check("bp_out3_valid", 32'(out_valid), 32'd1);
    check("bp_out3_o", o, 32'h99AA_BBCC);
    step();
    check("bp_drained_valid", 32'(out_valid), 32'd0);
    check("bp_cnt", 32'(beat_cnt), 32'd104);

    // OR and XOR modes
    a = 32'h0000_0001;
    b = 32'h8000_0000;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    check("or_o", or_o, 32'h8000_0001);
    check("or_red", 32'(or_red), 32'b1001);
    check("or_and_o", o, 32'h0000_0000);
    check("or_and_red", 32'(red), 32'b0000);
    a = 32'hDEAD_BEEF;
    b = 32'hDEAD_BEEF;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    check("xor_valid", 32'(xor_out_valid), 32'd1);
    check("xor_o", xor_o, 32'h0000_0000);
    check("xor_red", 32'(xor_red), 32'b0000);
    check("xor_and_o", o, 32'hDEAD_BEEF);
    step();

    // counter wrap on the CNT_W=4 instance
    rst_n = 1'b0;
    #2;
    check("wrap_rst_cnt", 32'(xor_cnt), 32'd0);
    step();
    rst_n = 1'b1;
    out_ready = 1'b1;
    b = 32'h0000_00FF;
    for (int k = 0; k < 20; k++) begin
      in_valid = (k < 17);
      a = 32'(k);
      step();
      if (k == 16) check("wrap_cnt15", 32'(xor_cnt), 32'd15);
      if (k == 17) check("wrap_cnt0", 32'(xor_cnt), 32'd0);
      if (k == 18) check("wrap_cnt1", 32'(xor_cnt), 32'd1);
    end
    check("wrap_wide_cnt", 32'(beat_cnt), 32'd17);

    // reset with beats in flight
    a = 32'hA5A5_A5A5;
    b = 32'hFFFF_FFFF;
    in_valid = 1'b1;
    step();
    a = 32'h3C3C_3C3C;
    step();
    in_valid = 1'b0;
    check("mid_pre_valid", 32'(out_valid), 32'd1);
    check("mid_pre_cnt", 32'(beat_cnt), 32'd17);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", 32'(out_valid), 32'd0);
    check("mid_rst_cnt", 32'(beat_cnt), 32'd0);
    check("mid_rst_o", o, 32'd0);
    check("mid_rst_ready", 32'(in_ready), 32'd1);
    step();
    #2;
    rst_n = 1'b1;
    step();
    check("mid_discard_valid", 32'(out_valid), 32'd0);
    a = 32'h0F0F_F0F0;
    b = 32'hFFFF_00FF;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    check("mid_lat1_valid", 32'(out_valid), 32'd0);
    step();
    check("mid_lat2_valid", 32'(out_valid), 32'd1);
    check("mid_o", o, 32'h0F0F_00F0);
    check("mid_red", 32'(red), 32'b1101);
    step();
    check("mid_cnt", 32'(beat_cnt), 32'd1);
    check("mid_or_cnt", 32'(or_cnt), 32'd1);
    check("mid_xor_cnt", 32'(xor_cnt), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
